neurram_spi_responder: RTL and testbench

//  Chip-side end of the 2-lane NeuRRAM scan/SPI link. Receives spi_clk + 2 data lanes from the FPGA

---
 rtl/neurram_spi_pkg.sv | 14 +
 rtl/neurram_spi_responder_if.sv | 22 ++
 rtl/neurram_sync_edge.sv | 48 ++++
 rtl/neurram_spi_responder.sv | 181 ++++++++++++++++++
 tb/tb_neurram_spi_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/neurram_spi_pkg.sv
// NeuRRAM 2-lane scan/SPI responder: shared types and constants.
// Imported by the interface, the synchronizer and the top.
package neurram_spi_pkg;

  localparam int NUM_LANES      = 2;
  localparam int DEF_SPI_LENGTH = 256;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/neurram_spi_responder_if.sv
// Serial link between the FPGA shift controller and the chain responder.
// The controller drives clock and lane data; the responder drives lane LSBs back.
interface neurram_spi_responder_if;
  import neurram_spi_pkg::*;

  logic                 spi_clk_in;
  logic [NUM_LANES-1:0] spi_din;
  logic [NUM_LANES-1:0] spi_dout;

  modport master (
    output spi_clk_in,
    output spi_din,
    input  spi_dout
  );

  modport slave (
    input  spi_clk_in,
    input  spi_din,
    output spi_dout
  );

endinterface

// File: rtl/neurram_sync_edge.sv
// N-stage synchronizer over {data, clock}; bit 0 is the serial clock.
// Rise/fall pulses come from the synchronized clock so data stays aligned.
module neurram_sync_edge #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-2:0] o_data,
  output logic             o_rise,
  output logic             o_fall
);

  logic [WIDTH-1:0] w_q;
  logic             r_prev;

  if (STAGES == 0) begin : g_bypass
    assign w_q = i_d;
  end else begin : g_sync
    logic [WIDTH-1:0] r_sync [STAGES];

    // shift the raw inputs through the synchronizer chain
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++)
          r_sync[i] <= '0;
      end else begin
        r_sync[0] <= i_d;
        for (int i = 1; i < STAGES; i++)
          r_sync[i] <= r_sync[i-1];
      end
    end

    assign w_q = r_sync[STAGES-1];
  end

  // previous synchronized clock level for edge detection
  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_q[0];
  end

  assign o_data = w_q[WIDTH-1:1];
  assign o_rise = w_q[0] & ~r_prev;
  assign o_fall = ~w_q[0] & r_prev;

endmodule

// File: rtl/neurram_spi_responder.sv
// Chip-side end of the 2-lane NeuRRAM scan link: two shift chains,
// frame capture, preload, and a mid-frame inactivity abort.
module neurram_spi_responder
  import neurram_spi_pkg::*;
#(
  parameter int SPI_LENGTH     = DEF_SPI_LENGTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4095,
  localparam int CW = $clog2(SPI_LENGTH),
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  neurram_spi_responder_if.slave spi,
  input  logic                  i_load_en,
  input  logic [SPI_LENGTH-1:0] i_load_data0,
  input  logic [SPI_LENGTH-1:0] i_load_data1,
  output logic [SPI_LENGTH-1:0] o_capture0,
  output logic [SPI_LENGTH-1:0] o_capture1,
  output logic [CW-1:0]         o_bit_count,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_load_err,
  output logic                  o_timeout_err
);

  state_t r_state, w_state_nx;

  logic [NUM_LANES-1:0]  w_din;
  logic                  w_rise, w_fall, w_edge;
  logic [NUM_LANES-1:0]  r_samp, r_dout;
  logic [CW-1:0]         r_bit_count;
  logic [IW-1:0]         r_idle_cnt;
  logic [SPI_LENGTH-1:0] r_chain0, r_chain1;
  logic [SPI_LENGTH-1:0] w_chain0_sh, w_chain1_sh;
  logic [SPI_LENGTH-1:0] r_cap0, r_cap1;
  logic                  r_done, r_tmo, r_lerr;
  logic                  w_last, w_tmo_hit;
  logic                  w_samp_en, w_shift, w_done;
  logic                  w_tmo, w_load, w_lerr;

  neurram_sync_edge #(
    .WIDTH  (NUM_LANES + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    ({spi.spi_din, spi.spi_clk_in}),
    .o_data (w_din),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_edge    = w_rise | w_fall;
  assign w_last    = r_bit_count == CW'(SPI_LENGTH - 1);
  assign w_tmo_hit = r_idle_cnt == IW'(TIMEOUT_CYCLES - 1);

  assign w_chain0_sh = {r_samp[0], r_chain0[SPI_LENGTH-1:1]};
  assign w_chain1_sh = {r_samp[1], r_chain1[SPI_LENGTH-1:1]};

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // next state and per-cycle strobes; an edge always beats a timeout
  always_comb begin
    w_state_nx = r_state;
    w_samp_en  = 1'b0;
    w_shift    = 1'b0;
    w_done     = 1'b0;
    w_tmo      = 1'b0;
    w_load     = 1'b0;
    w_lerr     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_samp_en  = 1'b1;
          w_state_nx = S_HIGH;
        end
        if (i_load_en) begin
          if (w_edge) w_lerr = 1'b1;
          else        w_load = 1'b1;
        end
      end
      S_HIGH: begin
        w_lerr = i_load_en;
        if (w_fall) begin
          w_shift = 1'b1;
          if (w_last) begin
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_LOW;
          end
        end else if (!w_rise && w_tmo_hit) begin
          w_tmo      = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_LOW: begin
        w_lerr = i_load_en;
        if (w_rise) begin
          w_samp_en  = 1'b1;
          w_state_nx = S_HIGH;
        end else if (!w_fall && w_tmo_hit) begin
          w_tmo      = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // lane sample, chains and frame capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp   <= '0;
      r_chain0 <= '0;
      r_chain1 <= '0;
      r_cap0   <= '0;
      r_cap1   <= '0;
      r_dout   <= '0;
    end else begin
      if (w_samp_en) r_samp <= w_din;
      if (w_shift) begin
        r_chain0 <= w_chain0_sh;
        r_chain1 <= w_chain1_sh;
      end else if (w_load) begin
        r_chain0 <= i_load_data0;
        r_chain1 <= i_load_data1;
      end
      if (w_done) begin
        r_cap0 <= w_chain0_sh;
        r_cap1 <= w_chain1_sh;
      end
      r_dout <= {r_chain1[0], r_chain0[0]};
    end
  end

  // bit and inactivity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_count <= '0;
      r_idle_cnt  <= '0;
    end else begin
      if (w_done || w_tmo)
        r_bit_count <= '0;
      else if (w_shift)
        r_bit_count <= r_bit_count + 1'b1;
      if (w_edge || w_tmo || r_state == S_IDLE)
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // status pulses and sticky load error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_done <= w_done;
      r_tmo  <= w_tmo;
      r_lerr <= r_lerr | w_lerr;
    end
  end

  assign spi.spi_dout   = r_dout;
  assign o_capture0     = r_cap0;
  assign o_capture1     = r_cap1;
  assign o_bit_count    = r_bit_count;
  assign o_busy         = r_state != S_IDLE;
  assign o_frame_done   = r_done;
  assign o_load_err     = r_lerr;
  assign o_timeout_err  = r_tmo;

endmodule

// File: tb/tb_neurram_spi_responder.sv
// Bench for neurram_spi_responder: randomized frames against a
// shift-register model of both chains and the capture registers.
module tb_neurram_spi_responder;
  import neurram_spi_pkg::*;

  localparam int LEN = 256;
  localparam int TMO = 4095;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neurram_spi_responder_if bus ();
  neurram_spi_responder_if bus0 ();
  assign bus0.spi_clk_in = bus.spi_clk_in;
  assign bus0.spi_din    = bus.spi_din;

  logic           load_en, load_en0;
  logic [LEN-1:0] ld0, ld1, ldz0, ldz1;
  logic [LEN-1:0] cap0, cap1, capz0, capz1;
  logic [7:0]     bc, bcz;
  logic           busy, done, lerr, tmo;
  logic           busyz, donez, lerrz, tmoz;

  neurram_spi_responder #(
    .SPI_LENGTH(LEN), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .rst(rst), .spi(bus.slave),
    .i_load_en(load_en), .i_load_data0(ld0), .i_load_data1(ld1),
    .o_capture0(cap0), .o_capture1(cap1), .o_bit_count(bc),
    .o_busy(busy), .o_frame_done(done), .o_load_err(lerr),
    .o_timeout_err(tmo)
  );

  neurram_spi_responder #(
    .SPI_LENGTH(LEN), .SYNC_STAGES(0), .TIMEOUT_CYCLES(TMO)
  ) u_dut0 (
    .clk(clk), .rst(rst), .spi(bus0.slave),
    .i_load_en(load_en0), .i_load_data0(ldz0), .i_load_data1(ldz1),
    .o_capture0(capz0), .o_capture1(capz1), .o_bit_count(bcz),
    .o_busy(busyz), .o_frame_done(donez), .o_load_err(lerrz),
    .o_timeout_err(tmoz)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int n_tmo = 0;
  int H = 6;

  logic [LEN-1:0] m_ch0, m_ch1, m_cap0, m_cap1;

  always @(negedge clk) begin
    if (done) n_done++;
    if (tmo)  n_tmo++;
  end

  function automatic logic [LEN-1:0] rnd();
    logic [LEN-1:0] v;
    for (int i = 0; i < LEN / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic do_rst();
    bus.spi_clk_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_ch0 = '0; m_ch1 = '0; m_cap0 = '0; m_cap1 = '0;
  endtask

  task automatic do_load(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    @(negedge clk); ld0 = a; ld1 = b; load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
    m_ch0 = a; m_ch1 = b;
  endtask

  // lmode 1: load_en with the first detected rise; lmode 2: load_en in LOW at bit 10
  task automatic run_frame(input int n, input logic [LEN-1:0] d0,
                           input logic [LEN-1:0] d1, input int lmode,
                           output logic [LEN-1:0] r0, output logic [LEN-1:0] r1,
                           output logic [LEN-1:0] z0, output logic [LEN-1:0] z1);
    logic [LEN-1:0] m0, m1;
    r0 = '0; r1 = '0; z0 = '0; z1 = '0; m0 = '0; m1 = '0;
    for (int i = 0; i < n; i++) begin
      bus.spi_din = {d1[i], d0[i]};
      m0[i] = d0[i]; m1[i] = d1[i];
      if (lmode == 2 && i == 10) begin
        repeat (4) @(negedge clk);
        load_en = 1'b1; @(negedge clk); load_en = 1'b0;
        repeat (H - 5) @(negedge clk);
      end else repeat (H) @(negedge clk);
      r0[i] = bus.spi_dout[0];  r1[i] = bus.spi_dout[1];
      z0[i] = bus0.spi_dout[0]; z1[i] = bus0.spi_dout[1];
      bus.spi_clk_in = 1'b1;
      if (lmode == 1 && i == 0) begin
        repeat (2) @(negedge clk);
        load_en = 1'b1; @(negedge clk); load_en = 1'b0;
        repeat (H - 3) @(negedge clk);
      end else repeat (H) @(negedge clk);
      bus.spi_clk_in = 1'b0;
    end
    repeat (H + 4) @(negedge clk);
    m_ch0 = (m_ch0 >> n) | (m0 << (LEN - n));
    m_ch1 = (m_ch1 >> n) | (m1 << (LEN - n));
    if (n == LEN) begin m_cap0 = m_ch0; m_cap1 = m_ch1; end
  endtask

  task automatic test_reset();
    n_vec++; if (bus.spi_dout !== 2'b00) begin n_err++;
      $display("FAIL rst_dout got %b want 00", bus.spi_dout); end
    n_vec++; if (cap0 !== '0) begin n_err++;
      $display("FAIL rst_cap0 got %h want 0", cap0); end
    n_vec++; if (cap1 !== '0) begin n_err++;
      $display("FAIL rst_cap1 got %h want 0", cap1); end
    n_vec++; if (bc !== 8'd0) begin n_err++;
      $display("FAIL rst_bit_count got %0d want 0", bc); end
    n_vec++; if ({busy, done, lerr, tmo} !== 4'b0) begin n_err++;
      $display("FAIL rst_flags got %b want 0000", {busy, done, lerr, tmo}); end
  endtask

  task automatic test_preload();
    logic [LEN-1:0] e0, e1, r0, r1, z0, z1, a, d0, d1;
    int k;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        a = {32{8'hA5}}; d0 = {32{8'h3C}}; d1 = {32{8'hC3}};
      end else begin
        a = rnd(); d0 = rnd(); d1 = rnd();
      end
      do_load(a, ~a);
      e0 = m_ch0; e1 = m_ch1; k = n_done;
      run_frame(LEN, d0, d1, 0, r0, r1, z0, z1);
      n_vec++; if (r0 !== e0) begin n_err++;
        $display("FAIL preload_rd0 it%0d got %h want %h", it, r0, e0); end
      n_vec++; if (r1 !== e1) begin n_err++;
        $display("FAIL preload_rd1 it%0d got %h want %h", it, r1, e1); end
      n_vec++; if (cap0 !== m_cap0) begin n_err++;
        $display("FAIL preload_cap0 it%0d got %h want %h", it, cap0, m_cap0); end
      n_vec++; if (cap1 !== m_cap1) begin n_err++;
        $display("FAIL preload_cap1 it%0d got %h want %h", it, cap1, m_cap1); end
      n_vec++; if (n_done - k !== 1) begin n_err++;
        $display("FAIL preload_done it%0d got %0d want 1", it, n_done - k); end
      n_vec++; if ({busy, bc} !== 9'd0) begin n_err++;
        $display("FAIL preload_idle it%0d got %b/%0d want 0/0", it, busy, bc); end
    end
  endtask

  task automatic test_back_to_back();
    logic [LEN-1:0] e0, e1, r0, r1, z0, z1;
    for (int f = 0; f < 3; f++) begin
      e0 = m_ch0; e1 = m_ch1;
      run_frame(LEN, rnd(), rnd(), 0, r0, r1, z0, z1);
      if (f > 0) begin
        n_vec++; if ({r1, r0} !== {e1, e0}) begin n_err++;
          $display("FAIL b2b_rd f%0d got %h %h want %h %h", f, r1, r0, e1, e0); end
      end
      n_vec++; if (bc !== 8'd0) begin n_err++;
        $display("FAIL b2b_bit_count f%0d got %0d want 0", f, bc); end
      n_vec++; if ({cap1, cap0} !== {m_cap1, m_cap0}) begin n_err++;
        $display("FAIL b2b_cap f%0d got %h want %h", f, cap0, m_cap0); end
    end
  endtask

  task automatic test_timeout();
    logic [LEN-1:0] e0, e1, r0, r1, z0, z1, mk;
    int k;
    mk = '0;
    for (int i = 0; i < 100; i++) mk[i] = 1'b1;
    e0 = m_ch0; e1 = m_ch1; k = n_tmo;
    run_frame(100, rnd(), rnd(), 0, r0, r1, z0, z1);
    n_vec++; if ({r1, r0} !== {e1 & mk, e0 & mk}) begin n_err++;
      $display("FAIL tmo_partial_rd got %h want %h", r0, e0 & mk); end
    n_vec++; if ({busy, bc} !== {1'b1, 8'd100}) begin n_err++;
      $display("FAIL tmo_midframe got %b/%0d want 1/100", busy, bc); end
    repeat (TMO + 20) @(negedge clk);
    n_vec++; if (n_tmo - k !== 1) begin n_err++;
      $display("FAIL tmo_pulse got %0d want 1", n_tmo - k); end
    n_vec++; if ({busy, bc} !== 9'd0) begin n_err++;
      $display("FAIL tmo_idle got %b/%0d want 0/0", busy, bc); end
    n_vec++; if ({cap1, cap0} !== {m_cap1, m_cap0}) begin n_err++;
      $display("FAIL tmo_cap got %h want %h", cap0, m_cap0); end
    e0 = m_ch0; e1 = m_ch1;
    run_frame(LEN, rnd(), rnd(), 0, r0, r1, z0, z1);
    n_vec++; if ({r1, r0} !== {e1, e0}) begin n_err++;
      $display("FAIL tmo_shift100 got %h want %h", r0, e0); end
  endtask

  task automatic test_load_err();
    logic [LEN-1:0] e0, e1, r0, r1, z0, z1;
    for (int m = 1; m <= 2; m++) begin
      ld0 = rnd(); ld1 = rnd();
      e0 = m_ch0; e1 = m_ch1;
      run_frame(LEN, rnd(), rnd(), m, r0, r1, z0, z1);
      n_vec++; if ({r1, r0} !== {e1, e0}) begin n_err++;
        $display("FAIL lerr_rd m%0d got %h want %h", m, r0, e0); end
      n_vec++; if ({cap1, cap0} !== {m_cap1, m_cap0}) begin n_err++;
        $display("FAIL lerr_cap m%0d got %h want %h", m, cap0, m_cap0); end
      n_vec++; if (lerr !== 1'b1) begin n_err++;
        $display("FAIL lerr_flag m%0d got %b want 1", m, lerr); end
    end
    do_rst();
    n_vec++; if (lerr !== 1'b0) begin n_err++;
      $display("FAIL lerr_clear got %b want 0", lerr); end
  endtask

  task automatic test_rst_mid();
    logic [LEN-1:0] d0, d1, r0, r1, z0, z1;
    do_load(rnd(), rnd());
    run_frame(LEN, rnd(), rnd(), 0, r0, r1, z0, z1);
    run_frame(128, rnd(), rnd(), 0, r0, r1, z0, z1);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if ({bus.spi_dout, bc, busy, done, lerr, tmo} !== 14'd0) begin n_err++;
      $display("FAIL rstmid_flags got %b %0d %b want 0", bus.spi_dout, bc,
               {busy, done, lerr, tmo}); end
    n_vec++; if ({cap1, cap0} !== '0) begin n_err++;
      $display("FAIL rstmid_cap got %h want 0", cap0); end
    rst = 1'b0;
    m_ch0 = '0; m_ch1 = '0; m_cap0 = '0; m_cap1 = '0;
    d0 = rnd(); d1 = rnd();
    run_frame(LEN, d0, d1, 0, r0, r1, z0, z1);
    n_vec++; if ({r1, r0} !== '0) begin n_err++;
      $display("FAIL rstmid_rd got %h want 0", r0); end
    n_vec++; if ({cap1, cap0} !== {d1, d0}) begin n_err++;
      $display("FAIL rstmid_cap2 got %h want %h", cap0, d0); end
  endtask

  task automatic test_sync_bypass();
    logic [LEN-1:0] p0, p1, d0, d1, r0, r1, z0, z1;
    H = 2;
    do_rst();
    for (int f = 0; f < 4; f++) begin
      p0 = rnd(); p1 = rnd(); d0 = rnd(); d1 = rnd();
      @(negedge clk); ldz0 = p0; ldz1 = p1; load_en0 = 1'b1;
      @(negedge clk); load_en0 = 1'b0;
      run_frame(LEN, d0, d1, 0, r0, r1, z0, z1);
      n_vec++; if ({z1, z0} !== {p1, p0}) begin n_err++;
        $display("FAIL bypass_rd f%0d got %h want %h", f, z0, p0); end
      n_vec++; if ({capz1, capz0} !== {d1, d0}) begin n_err++;
        $display("FAIL bypass_cap f%0d got %h want %h", f, capz0, d0); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.spi_clk_in = 1'b0; bus.spi_din = '0;
    load_en = 1'b0; load_en0 = 1'b0;
    ld0 = '0; ld1 = '0; ldz0 = '0; ldz1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_ch0 = '0; m_ch1 = '0; m_cap0 = '0; m_cap1 = '0;
    test_reset();
    test_preload();
    test_back_to_back();
    test_timeout();
    test_load_err();
    test_rst_mid();
    test_sync_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
